// File: rtl/dbg_trigger_unit.sv
// dbg_trigger_unit: parametrised breakpoint/watchpoint triggers with TSELECT/TDATA1/TDATA2/TINFO CSRs
//   clk, rst            : clock, asynchronous active-high reset
//   csr_*_i / csr_rdata_o : CSR write port (from exu) and combinational read port
//   debug_mode_i, priv_m_i : core state used for write gating and trigger enabling
//   pc_valid_i, pc_if_i : fetch address stream compared by execute triggers
//   lsu_*_i             : load/store address stream compared by load/store triggers
//   trig_*_o            : registered debug-entry requests and lowest firing trigger index
module dbg_trigger_unit #(
  parameter int TRIG_NUM = 4,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csr_we_i,
  input  logic [11:0]       csr_waddr_i,
  input  logic [31:0]       csr_wdata_i,
  input  logic [11:0]       csr_raddr_i,
  output logic [31:0]       csr_rdata_o,
  input  logic              debug_mode_i,
  input  logic              priv_m_i,
  input  logic              pc_valid_i,
  input  logic [ADDR_W-1:0] pc_if_i,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  output logic              trig_fetch_o,
  output logic              trig_lsu_o,
  output logic [3:0]        trig_idx_o
);
  localparam logic [11:0] TSELECT = 12'h7A0;
  localparam logic [11:0] TDATA1  = 12'h7A1;
  localparam logic [11:0] TDATA2  = 12'h7A2;
  localparam logic [11:0] TINFO   = 12'h7A4;
  logic [3:0]          tsel_q;
  logic [TRIG_NUM-1:0] m_q, u_q, ex_q, st_q, ld_q, hit_q, hit_d;
  logic [TRIG_NUM-1:0] en, fetch_hit, lsu_hit, wr1, wr2;
  logic [3:0]          match_q  [TRIG_NUM];
  logic [ADDR_W-1:0]   tdata2_q [TRIG_NUM];
  logic                fetch_q, lsu_q;
  logic [3:0]          idx_q, idx_d;
  logic [31:0]         sel_t1;
  logic [ADDR_W-1:0]   sel_t2;
  logic                legal;
  function automatic logic cmp(input logic [3:0] mt, input logic [ADDR_W-1:0] a,
                               input logic [ADDR_W-1:0] t);
    return (mt == 4'd2) ? (a >= t) : (mt == 4'd3) ? (a < t) : (a == t);
  endfunction
  // illegal match encodings disable the trigger instead of storing junk
  assign legal = (csr_wdata_i[10:7] == 4'd0) || (csr_wdata_i[10:7] == 4'd2) ||
                 (csr_wdata_i[10:7] == 4'd3);
  assign en = debug_mode_i ? '0 : (priv_m_i ? m_q : u_q);
  always_comb begin
    fetch_hit = '0;
    lsu_hit   = '0;
    wr1       = '0;
    wr2       = '0;
    idx_d     = idx_q;
    sel_t1    = '0;
    sel_t2    = '0;
    // descending scan so the lowest firing index is the last one written
    for (int i = TRIG_NUM - 1; i >= 0; i--) begin
      fetch_hit[i] = en[i] & ex_q[i] & pc_valid_i & cmp(match_q[i], pc_if_i, tdata2_q[i]);
      lsu_hit[i]   = en[i] & lsu_req_i & (lsu_we_i ? st_q[i] : ld_q[i]) &
                     cmp(match_q[i], lsu_addr_i, tdata2_q[i]);
      idx_d        = (fetch_hit[i] | lsu_hit[i]) ? 4'(i) : idx_d;
      wr1[i]       = csr_we_i & debug_mode_i & (tsel_q == 4'(i)) & (csr_waddr_i == TDATA1);
      wr2[i]       = csr_we_i & debug_mode_i & (tsel_q == 4'(i)) & (csr_waddr_i == TDATA2);
      sel_t1       = (tsel_q == 4'(i)) ?
                     {4'h2, 1'b1, 6'h0, hit_q[i], 4'h0, 4'h1, 1'b0, match_q[i], m_q[i],
                      2'b00, u_q[i], ex_q[i], st_q[i], ld_q[i]} : sel_t1;
      sel_t2       = (tsel_q == 4'(i)) ? tdata2_q[i] : sel_t2;
    end
    // a match in the same cycle overrides a software clear of hit
    hit_d = (hit_q & ~wr1) | ({TRIG_NUM{csr_wdata_i[20]}} & wr1) | fetch_hit | lsu_hit;
  end
  assign csr_rdata_o = (csr_raddr_i == TSELECT) ? {28'h0, tsel_q} :
                       (csr_raddr_i == TDATA1)  ? sel_t1 :
                       (csr_raddr_i == TDATA2)  ? 32'(sel_t2) :
                       (csr_raddr_i == TINFO)   ? 32'h4 : 32'h0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tsel_q  <= '0;
      m_q     <= '0;
      u_q     <= '0;
      ex_q    <= '0;
      st_q    <= '0;
      ld_q    <= '0;
      hit_q   <= '0;
      fetch_q <= 1'b0;
      lsu_q   <= 1'b0;
      idx_q   <= '0;
      for (int i = 0; i < TRIG_NUM; i++) begin
        match_q[i]  <= '0;
        tdata2_q[i] <= '0;
      end
    end else begin
      if (csr_we_i && csr_waddr_i == TSELECT)
        tsel_q <= (csr_wdata_i < 32'(TRIG_NUM)) ? csr_wdata_i[3:0] : 4'(TRIG_NUM - 1);
      for (int i = 0; i < TRIG_NUM; i++) begin
        if (wr1[i]) begin
          match_q[i] <= legal ? csr_wdata_i[10:7] : 4'd0;
          m_q[i]     <= csr_wdata_i[6];
          u_q[i]     <= csr_wdata_i[3];
          ex_q[i]    <= legal & csr_wdata_i[2];
          st_q[i]    <= legal & csr_wdata_i[1];
          ld_q[i]    <= legal & csr_wdata_i[0];
        end
        if (wr2[i])
          tdata2_q[i] <= csr_wdata_i[ADDR_W-1:0];
      end
      hit_q   <= hit_d;
      fetch_q <= |fetch_hit;
      lsu_q   <= |lsu_hit;
      idx_q   <= idx_d;
    end
  end
  assign trig_fetch_o = fetch_q;
  assign trig_lsu_o   = lsu_q;
  assign trig_idx_o   = idx_q;
endmodule
